alu_array_seq: RTL and testbench

- Parametrised, multi-channel successor to the fixed dual 4-bit ALU user-project macro.
- Accepts one operand set per transaction for NUM_CH channels.
- Evaluates the channels serially through one shared ALU datapath, one channel per cycle.
- Returns all results as one registered bundle over a valid/ready handshake.
- Adds per-channel accumulators, carry/borrow output and zero flags, none of which the previous generation has.
- Sits inside user_project_wrapper behind the mprj_io pin mapping.

---
 rtl/alu_array_seq_if.sv | 27 ++
 rtl/alu_array_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_array_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_array_seq_if.sv
// Handshake bundle for alu_array_seq: operand input channel, result output channel and busy.
// The slave modport is the ALU side and the master modport is the producer/consumer side.
interface alu_array_seq_if #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CH*WIDTH-1:0]       in_a;
    logic [NUM_CH*WIDTH-1:0]       in_b;
    logic [NUM_CH*3-1:0]           in_sel;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_CH*(WIDTH+1)-1:0]   out_res;
    logic [NUM_CH-1:0]             out_zero;
    logic                          busy;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, out_ready,
        output in_ready, out_valid, out_res, out_zero, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, out_ready,
        input  in_ready, out_valid, out_res, out_zero, busy
    );
endinterface

// File: rtl/alu_array_seq.sv
// Multi-channel ALU: latches one operand bundle, evaluates one channel per cycle through a
// shared datapath and presents the whole result bundle on a valid/ready handshake.
module alu_array_seq #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 4
) (
    input logic            wb_clk_i,
    input logic            wb_rst_i,
    alu_array_seq_if.slave bus
);

    localparam int RW    = WIDTH + 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_ACC   = 3'd5,
        OP_CLR   = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [NUM_CH*WIDTH-1:0]  a_q;
    logic [NUM_CH*WIDTH-1:0]  b_q;
    logic [NUM_CH*3-1:0]      sel_q;
    logic [WIDTH-1:0]         acc_q [NUM_CH];
    logic [NUM_CH*RW-1:0]     res_q;
    logic [NUM_CH-1:0]        zero_q;
    logic                     out_valid_q;
    logic                     busy_q;

    logic [WIDTH-1:0]         ch_a;
    logic [WIDTH-1:0]         ch_b;
    logic [WIDTH-1:0]         ch_acc;
    op_e                      ch_op;
    logic [RW-1:0]            alu_res_d;
    logic                     alu_zero_d;
    logic                     acc_wr_d;
    logic [WIDTH-1:0]         acc_d;

    // Operand select for the channel currently being evaluated.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ch_a   = '0;
        ch_b   = '0;
        ch_acc = '0;
        ch_op  = OP_ADD;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                ch_a   = a_q[i*WIDTH +: WIDTH];
                ch_b   = b_q[i*WIDTH +: WIDTH];
                ch_acc = acc_q[i];
                ch_op  = op_e'(sel_q[i*3 +: 3]);
            end
        end
    end

    always_comb begin
        alu_res_d = '0;
        acc_wr_d  = 1'b0;
        acc_d     = '0;
        case (ch_op)
            OP_ADD:   alu_res_d = {1'b0, ch_a} + {1'b0, ch_b};
            OP_SUB:   alu_res_d = {(ch_a < ch_b), ch_a - ch_b};
            OP_AND:   alu_res_d = {1'b0, ch_a & ch_b};
            OP_OR:    alu_res_d = {1'b0, ch_a | ch_b};
            OP_XOR:   alu_res_d = {1'b0, ch_a ^ ch_b};
            OP_ACC: begin
                alu_res_d = {1'b0, ch_acc} + {1'b0, ch_a};
                acc_wr_d  = 1'b1;
                acc_d     = alu_res_d[WIDTH-1:0];
            end
            OP_CLR: begin
                alu_res_d = '0;
                acc_wr_d  = 1'b1;
                acc_d     = '0;
            end
            OP_PASSB: alu_res_d = {1'b0, ch_b};
            default:  alu_res_d = '0;
        endcase
    end

    // The zero flag ignores the carry/borrow bit.
    assign alu_zero_d = ~|alu_res_d[WIDTH-1:0];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            res_q       <= '0;
            zero_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            // NOTE: the accumulator array is architecturally visible state, so it is reset like any register.
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        sel_q   <= bus.in_sel;
                        res_q   <= '0;
                        zero_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            res_q[i*RW +: RW] <= alu_res_d;
                            zero_q[i]         <= alu_zero_d;
                            if (acc_wr_d) begin
                                acc_q[i] <= acc_d;
                            end
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Ready drops combinationally with reset so nothing is offered while it is asserted.
    assign bus.in_ready  = (state_q == S_IDLE) & ~wb_rst_i;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = res_q;
    assign bus.out_zero  = zero_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_array_seq.sv
// Scoreboard bench for alu_array_seq: a bench-side model predicts each bundle when it is sent,
// and the prediction is popped and compared when the result bundle appears.
module tb_alu_array_seq;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 4;
    localparam int RW     = WIDTH + 1;

    typedef struct packed {
        logic [NUM_CH*RW-1:0] res;
        logic [NUM_CH-1:0]    zero;
    } exp_t;

    logic wb_clk_i;
    logic wb_rst_i;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q [$];
    logic [WIDTH-1:0] model_acc [NUM_CH];
    logic [NUM_CH*RW-1:0] res_seen;
    logic [NUM_CH-1:0]    zero_seen;

    alu_array_seq_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

    alu_array_seq #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Independent reference: integer arithmetic per opcode, updates the bench's accumulators.
    function automatic exp_t model_bundle(input logic [NUM_CH*WIDTH-1:0] a,
                                          input logic [NUM_CH*WIDTH-1:0] b,
                                          input logic [NUM_CH*3-1:0] sel);
        exp_t e;
        int ai, bi, diff, s;
        logic [RW-1:0] r;
        e = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ai = int'(a[ch*WIDTH +: WIDTH]);
            bi = int'(b[ch*WIDTH +: WIDTH]);
            r  = '0;
            case (sel[ch*3 +: 3])
                3'd0: r = RW'(ai + bi);
                3'd1: begin
                    diff = ai - bi;
                    r = RW'((diff + (1 << WIDTH)) % (1 << WIDTH));
                    r[WIDTH] = (diff < 0);
                end
                3'd2: r = RW'(ai & bi);
                3'd3: r = RW'(ai | bi);
                3'd4: r = RW'(ai ^ bi);
                3'd5: begin
                    s = int'(model_acc[ch]) + ai;
                    r = RW'(s);
                    model_acc[ch] = WIDTH'(s % (1 << WIDTH));
                end
                3'd6: begin
                    r = '0;
                    model_acc[ch] = '0;
                end
                default: r = RW'(bi);
            endcase
            e.res[ch*RW +: RW] = r;
            e.zero[ch] = (r[WIDTH-1:0] == '0);
        end
        return e;
    endfunction

    task automatic send(input logic [NUM_CH*WIDTH-1:0] a, input logic [NUM_CH*WIDTH-1:0] b,
                        input logic [NUM_CH*3-1:0] sel);
        int waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge wb_clk_i);
            waited++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = sel;
        bus.in_valid = 1'b1;
        exp_q.push_back(model_bundle(a, b, sel));
        @(posedge wb_clk_i);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge; measures latency, then optionally holds backpressure.
    task automatic collect(input int hold, output logic [NUM_CH*RW-1:0] res_o,
                           output logic [NUM_CH-1:0] zero_o);
        int lat = 0;
        exp_t e;
        bus.out_ready = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge wb_clk_i);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(NUM_CH));
        check("busy_done", 32'(bus.busy), 32'd1);
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("res", 32'(bus.out_res), 32'(e.res));
        check("zero", 32'(bus.out_zero), 32'(e.zero));
        res_o  = bus.out_res;
        zero_o = bus.out_zero;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_a     = 12'($urandom);
            bus.in_b     = 12'($urandom);
            bus.in_sel   = 9'($urandom);
            @(posedge wb_clk_i);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_res", 32'(bus.out_res), 32'(e.res));
            check("bp_zero", 32'(bus.out_zero), 32'(e.zero));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("handoff_valid", 32'(bus.out_valid), 32'd0);
        check("handoff_ready", 32'(bus.in_ready), 32'd1);
        check("handoff_busy", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        wb_rst_i      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) model_acc[i] = '0;

        // Reset held for five cycles.
        repeat (5) begin
            @(negedge wb_clk_i);
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        end
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res", 32'(bus.out_res), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        wb_rst_i = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // ADD 9+9, SUB 3-5, AND C&A with ten cycles of backpressure.
        @(negedge wb_clk_i);
        send({4'hC, 4'h3, 4'h9}, {4'hA, 4'h5, 4'h9}, {3'd2, 3'd1, 3'd0});
        collect(10, res_seen, zero_seen);
        check("basic_res_const", 32'(res_seen), 32'({5'b01000, 5'b11110, 5'b10010}));
        check("basic_zero_const", 32'(zero_seen), 32'd0);

        // ch0 accumulate 7 three times, clear, then accumulate 2.
        for (int k = 0; k < 3; k++) begin
            send({4'h5, 4'h2, 4'h7}, {4'h5, 4'h1, 4'h0}, {3'd7, 3'd0, 3'd5});
            collect(0, res_seen, zero_seen);
            case (k)
                0: check("acc1_slot0", 32'(res_seen[4:0]), 32'h07);
                1: check("acc2_slot0", 32'(res_seen[4:0]), 32'h0E);
                default: check("acc3_slot0", 32'(res_seen[4:0]), 32'h15);
            endcase
        end
        send({4'h5, 4'h2, 4'h7}, {4'h5, 4'h1, 4'h0}, {3'd7, 3'd0, 3'd6});
        collect(0, res_seen, zero_seen);
        check("clr_slot0", 32'(res_seen[4:0]), 32'h00);
        check("clr_zero0", 32'(zero_seen[0]), 32'd1);
        send({4'h0, 4'h0, 4'h2}, {4'h0, 4'h0, 4'h0}, {3'd7, 3'd0, 3'd5});
        collect(0, res_seen, zero_seen);
        check("acc_after_clr", 32'(res_seen[4:0]), 32'h02);

        // ACC 6 history, then reset in the second RUN cycle of another ACC 6.
        send({4'h0, 4'h0, 4'h6}, {4'h0, 4'h0, 4'h0}, {3'd7, 3'd0, 3'd5});
        collect(0, res_seen, zero_seen);
        check("acc6_slot0", 32'(res_seen[4:0]), 32'h08);
        send({4'h0, 4'h0, 4'h6}, {4'h0, 4'h0, 4'h0}, {3'd7, 3'd0, 3'd5});
        @(posedge wb_clk_i);
        #1;
        check("midrun_busy_before", 32'(bus.busy), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check("midrun_valid", 32'(bus.out_valid), 32'd0);
        check("midrun_busy", 32'(bus.busy), 32'd0);
        check("midrun_in_ready", 32'(bus.in_ready), 32'd0);
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) model_acc[i] = '0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        send({4'h0, 4'h0, 4'h3}, {4'h0, 4'h0, 4'h0}, {3'd7, 3'd0, 3'd5});
        collect(0, res_seen, zero_seen);
        check("acc_after_rst", 32'(res_seen[4:0]), 32'h03);

        // Zero and edge operations: PASSB A, XOR F^F, SUB 0-0.
        send({4'h0, 4'hF, 4'h0}, {4'h0, 4'hF, 4'hA}, {3'd1, 3'd4, 3'd7});
        collect(0, res_seen, zero_seen);
        check("edge_res_const", 32'(res_seen), 32'({5'h00, 5'h00, 5'h0A}));
        check("edge_zero_const", 32'(zero_seen), 32'b110);

        // Random bundles with mixed backpressure.
        for (int k = 0; k < 12; k++) begin
            send(12'($urandom), 12'($urandom), 9'($urandom));
            collect(int'($urandom_range(0, 2)), res_seen, zero_seen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
